// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       equal;
    logic       lessThan;
    logic       halt;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_write;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write_en;
    logic       alu_b_sel;
    logic       branch_unsigned;
    logic [1:0] alu_a_sel;
    logic [1:0] wb_sel;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, funct7, equal, lessThan, halt, mem_ready,
        output mem_req, mem_write, mem_addr_sel, ir_write, pc_write, reg_write_en,
               alu_b_sel, branch_unsigned, alu_a_sel, wb_sel, pc_src, alu_op,
               instr_done, illegal, state_o
    );

    modport slave (
        output opcode, funct3, funct7, equal, lessThan, halt, mem_ready,
        input  mem_req, mem_write, mem_addr_sel, ir_write, pc_write, reg_write_en,
               alu_b_sel, branch_unsigned, alu_a_sel, wb_sel, pc_src, alu_op,
               instr_done, illegal, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-style control FSM: fetch/decode/execute/memory/writeback sequencing.
// Outputs are Moore/Mealy decodes of the state and are forced low while rst_n is low.
//
// state  | meaning
// FETCH  | request instruction at PC; on grant latch IR and advance PC
// DECODE | classify opcode, reject illegal encodings
// EXEC   | ALU operation for ALU/LUI/AUIPC/address generation
// MEM_RD | load request at ALU address, held until granted
// MEM_WR | store request at ALU address, retires on grant
// WB     | register writeback, retire
// BRANCH | target compute, conditional PC write, retire
// JUMP   | link writeback and PC write, retire
// TRAP   | illegal instruction, parked until reset
module multicycle_controller (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_MEM_RD = 4'd3;
    localparam logic [3:0] S_MEM_WR = 4'd4;
    localparam logic [3:0] S_WB     = 4'd5;
    localparam logic [3:0] S_BRANCH = 4'd6;
    localparam logic [3:0] S_JUMP   = 4'd7;
    localparam logic [3:0] S_TRAP   = 4'd8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    logic [3:0] state_q, state_d;

    logic       r_legal, i_legal, br_legal, br_taken;
    logic [3:0] r_alu_op, i_alu_op;

    logic       mem_req, mem_write, mem_addr_sel, ir_write, pc_write, reg_write_en;
    logic       alu_b_sel, branch_unsigned, instr_done, illegal;
    logic [1:0] alu_a_sel, wb_sel, pc_src;
    logic [3:0] alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        r_legal  = 1'b1;
        r_alu_op = ALU_ADD;
        case ({bus.funct7, bus.funct3})
            10'b0000000_000: r_alu_op = ALU_ADD;
            10'b0100000_000: r_alu_op = ALU_SUB;
            10'b0000000_001: r_alu_op = ALU_SLL;
            10'b0000000_010: r_alu_op = ALU_SLT;
            10'b0000000_011: r_alu_op = ALU_SLTU;
            10'b0000000_100: r_alu_op = ALU_XOR;
            10'b0000000_101: r_alu_op = ALU_SRL;
            10'b0100000_101: r_alu_op = ALU_SRA;
            10'b0000000_110: r_alu_op = ALU_OR;
            10'b0000000_111: r_alu_op = ALU_AND;
            default:         r_legal  = 1'b0;
        endcase
    end

    always_comb begin
        i_alu_op = ALU_ADD;
        case (bus.funct3)
            3'b000:  i_alu_op = ALU_ADD;
            3'b001:  i_alu_op = ALU_SLL;
            3'b010:  i_alu_op = ALU_SLT;
            3'b011:  i_alu_op = ALU_SLTU;
            3'b100:  i_alu_op = ALU_XOR;
            3'b101:  i_alu_op = (bus.funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            3'b110:  i_alu_op = ALU_OR;
            default: i_alu_op = ALU_AND;
        endcase
    end

    // Only the shift-left immediate has a constrained upper field; srli/srai fall back to srl.
    assign i_legal  = !((bus.funct3 == 3'b001) && (bus.funct7 != 7'b0000000));
    assign br_legal = (bus.funct3 != 3'b010) && (bus.funct3 != 3'b011);

    always_comb begin
        br_taken = 1'b0;
        case (bus.funct3)
            3'b000:         br_taken = bus.equal;
            3'b001:         br_taken = !bus.equal;
            3'b100, 3'b110: br_taken = bus.lessThan;
            3'b101, 3'b111: br_taken = !bus.lessThan;
            default:        br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        mem_addr_sel    = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        reg_write_en    = 1'b0;
        alu_b_sel       = 1'b0;
        branch_unsigned = 1'b0;
        instr_done      = 1'b0;
        illegal         = 1'b0;
        alu_a_sel       = 2'b00;
        wb_sel          = 2'b00;
        pc_src          = 2'b00;
        alu_op          = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                if (!bus.halt) begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
                case (bus.opcode)
                    OP_R:                              state_d = r_legal  ? S_EXEC   : S_TRAP;
                    OP_I:                              state_d = i_legal  ? S_EXEC   : S_TRAP;
                    OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC: state_d = S_EXEC;
                    OP_BRANCH:                         state_d = br_legal ? S_BRANCH : S_TRAP;
                    OP_JAL, OP_JALR:                   state_d = S_JUMP;
                    default:                           state_d = S_TRAP;
                endcase
            end

            S_EXEC: begin
                alu_b_sel = 1'b1;
                case (bus.opcode)
                    OP_R: begin
                        alu_b_sel = 1'b0;
                        alu_op    = r_alu_op;
                    end
                    OP_I:     alu_op    = i_alu_op;
                    OP_LUI:   alu_a_sel = 2'b10;
                    OP_AUIPC: alu_a_sel = 2'b01;
                    default:  alu_op    = ALU_ADD;
                endcase
                if (bus.opcode == OP_LOAD)       state_d = S_MEM_RD;
                else if (bus.opcode == OP_STORE) state_d = S_MEM_WR;
                else                             state_d = S_WB;
            end

            S_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (bus.mem_ready) state_d = S_WB;
            end

            S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_write    = 1'b1;
                mem_addr_sel = 1'b1;
                if (bus.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_WB: begin
                reg_write_en = 1'b1;
                instr_done   = 1'b1;
                wb_sel       = (bus.opcode == OP_LOAD) ? 2'b01 : 2'b00;
                state_d      = S_FETCH;
            end

            S_BRANCH: begin
                alu_a_sel       = 2'b01;
                alu_b_sel       = 1'b1;
                pc_src          = 2'b01;
                branch_unsigned = bus.funct3[2] & bus.funct3[1];
                pc_write        = br_taken;
                instr_done      = 1'b1;
                state_d         = S_FETCH;
            end

            S_JUMP: begin
                alu_b_sel    = 1'b1;
                reg_write_en = 1'b1;
                wb_sel       = 2'b10;
                pc_write     = 1'b1;
                instr_done   = 1'b1;
                if (bus.opcode == OP_JALR) begin
                    alu_a_sel = 2'b00;
                    pc_src    = 2'b10;
                end else begin
                    alu_a_sel = 2'b01;
                    pc_src    = 2'b01;
                end
                state_d = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Gate with rst_n so a pending request or write drops the instant reset asserts.
    assign bus.mem_req         = rst_n & mem_req;
    assign bus.mem_write       = rst_n & mem_write;
    assign bus.mem_addr_sel    = rst_n & mem_addr_sel;
    assign bus.ir_write        = rst_n & ir_write;
    assign bus.pc_write        = rst_n & pc_write;
    assign bus.reg_write_en    = rst_n & reg_write_en;
    assign bus.alu_b_sel       = rst_n & alu_b_sel;
    assign bus.branch_unsigned = rst_n & branch_unsigned;
    assign bus.instr_done      = rst_n & instr_done;
    assign bus.illegal         = rst_n & illegal;
    assign bus.alu_a_sel       = {2{rst_n}} & alu_a_sel;
    assign bus.wb_sel          = {2{rst_n}} & wb_sel;
    assign bus.pc_src          = {2{rst_n}} & pc_src;
    assign bus.alu_op          = {4{rst_n}} & alu_op;
    assign bus.state_o         = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle traces built from an
// instruction table and the sequencing rules, replayed with random waits and noise.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwr, asel, irw, pcw;
        logic [1:0] pcs;
        logic       rwe;
        logic [1:0] wbs;
        logic [1:0] asl;
        logic       bsl;
        logic [3:0] aop;
        logic       bu, done, ill;
    } exp_t;

    localparam logic [2:0] C_ALU = 3'd0, C_LD = 3'd1, C_ST = 3'd2, C_BR = 3'd3,
                           C_JAL = 3'd4, C_JALR = 3'd5, C_TRAP = 3'd6;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] cls;
        logic [3:0] aop;
        logic [1:0] a;
        logic       b;
    } ins_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       rdy, hlt, eq, lt;
        exp_t       e;
    } step_t;

    localparam int NINS = 40;
    ins_t  tbl [NINS];
    step_t q[$];
    ins_t  cur;
    int    total = 0;
    int    bad   = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t z(logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = {bus.state_o, bus.mem_req, bus.mem_write, bus.mem_addr_sel, bus.ir_write,
             bus.pc_write, bus.pc_src, bus.reg_write_en, bus.wb_sel, bus.alu_a_sel,
             bus.alu_b_sel, bus.alu_op, bus.branch_unsigned, bus.instr_done, bus.illegal};
        return o;
    endfunction

    // Branch conditions by mnemonic: beq, bne, blt, bge, bltu, bgeu.
    function automatic logic taken(logic [2:0] f3, logic eq, logic lt);
        case (f3)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return lt;
            3'd7:    return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic init_tbl();
        tbl[0]  = '{7'h33, 3'd0, 7'h00, C_ALU, 4'd0, 2'd0, 1'b0};  // add
        tbl[1]  = '{7'h33, 3'd0, 7'h20, C_ALU, 4'd1, 2'd0, 1'b0};  // sub
        tbl[2]  = '{7'h33, 3'd1, 7'h00, C_ALU, 4'd2, 2'd0, 1'b0};
        tbl[3]  = '{7'h33, 3'd2, 7'h00, C_ALU, 4'd3, 2'd0, 1'b0};
        tbl[4]  = '{7'h33, 3'd3, 7'h00, C_ALU, 4'd4, 2'd0, 1'b0};
        tbl[5]  = '{7'h33, 3'd4, 7'h00, C_ALU, 4'd5, 2'd0, 1'b0};
        tbl[6]  = '{7'h33, 3'd5, 7'h00, C_ALU, 4'd6, 2'd0, 1'b0};
        tbl[7]  = '{7'h33, 3'd5, 7'h20, C_ALU, 4'd7, 2'd0, 1'b0};
        tbl[8]  = '{7'h33, 3'd6, 7'h00, C_ALU, 4'd8, 2'd0, 1'b0};
        tbl[9]  = '{7'h33, 3'd7, 7'h00, C_ALU, 4'd9, 2'd0, 1'b0};
        tbl[10] = '{7'h13, 3'd0, 7'h15, C_ALU, 4'd0, 2'd0, 1'b1};  // addi
        tbl[11] = '{7'h13, 3'd1, 7'h00, C_ALU, 4'd2, 2'd0, 1'b1};
        tbl[12] = '{7'h13, 3'd2, 7'h7f, C_ALU, 4'd3, 2'd0, 1'b1};
        tbl[13] = '{7'h13, 3'd3, 7'h00, C_ALU, 4'd4, 2'd0, 1'b1};
        tbl[14] = '{7'h13, 3'd4, 7'h00, C_ALU, 4'd5, 2'd0, 1'b1};
        tbl[15] = '{7'h13, 3'd5, 7'h00, C_ALU, 4'd6, 2'd0, 1'b1};
        tbl[16] = '{7'h13, 3'd5, 7'h20, C_ALU, 4'd7, 2'd0, 1'b1};
        tbl[17] = '{7'h13, 3'd5, 7'h11, C_ALU, 4'd6, 2'd0, 1'b1};
        tbl[18] = '{7'h13, 3'd6, 7'h00, C_ALU, 4'd8, 2'd0, 1'b1};
        tbl[19] = '{7'h13, 3'd7, 7'h00, C_ALU, 4'd9, 2'd0, 1'b1};
        tbl[20] = '{7'h03, 3'd2, 7'h00, C_LD,  4'd0, 2'd0, 1'b1};  // lw
        tbl[21] = '{7'h03, 3'd4, 7'h00, C_LD,  4'd0, 2'd0, 1'b1};
        tbl[22] = '{7'h23, 3'd2, 7'h00, C_ST,  4'd0, 2'd0, 1'b1};  // sw
        tbl[23] = '{7'h37, 3'd0, 7'h00, C_ALU, 4'd0, 2'd2, 1'b1};  // lui
        tbl[24] = '{7'h17, 3'd0, 7'h00, C_ALU, 4'd0, 2'd1, 1'b1};  // auipc
        tbl[25] = '{7'h63, 3'd0, 7'h00, C_BR,  4'd0, 2'd1, 1'b1};
        tbl[26] = '{7'h63, 3'd1, 7'h00, C_BR,  4'd0, 2'd1, 1'b1};
        tbl[27] = '{7'h63, 3'd4, 7'h00, C_BR,  4'd0, 2'd1, 1'b1};
        tbl[28] = '{7'h63, 3'd5, 7'h00, C_BR,  4'd0, 2'd1, 1'b1};
        tbl[29] = '{7'h63, 3'd6, 7'h00, C_BR,  4'd0, 2'd1, 1'b1};  // bltu
        tbl[30] = '{7'h63, 3'd7, 7'h00, C_BR,  4'd0, 2'd1, 1'b1};  // bgeu
        tbl[31] = '{7'h6f, 3'd0, 7'h00, C_JAL, 4'd0, 2'd1, 1'b1};
        tbl[32] = '{7'h67, 3'd0, 7'h00, C_JALR,4'd0, 2'd0, 1'b1};  // jalr
        tbl[33] = '{7'h7f, 3'd0, 7'h00, C_TRAP,4'd0, 2'd0, 1'b0};
        tbl[34] = '{7'h00, 3'd0, 7'h00, C_TRAP,4'd0, 2'd0, 1'b0};
        tbl[35] = '{7'h33, 3'd0, 7'h01, C_TRAP,4'd0, 2'd0, 1'b0};  // mul
        tbl[36] = '{7'h33, 3'd1, 7'h20, C_TRAP,4'd0, 2'd0, 1'b0};
        tbl[37] = '{7'h13, 3'd1, 7'h01, C_TRAP,4'd0, 2'd0, 1'b0};
        tbl[38] = '{7'h63, 3'd2, 7'h00, C_TRAP,4'd0, 2'd0, 1'b0};
        tbl[39] = '{7'h63, 3'd3, 7'h00, C_TRAP,4'd0, 2'd0, 1'b0};
    endtask

    task automatic push(logic rdy, logic hlt, logic eq, logic lt, exp_t e);
        step_t s;
        s.op = cur.op; s.f3 = cur.f3; s.f7 = cur.f7;
        s.rdy = rdy; s.hlt = hlt; s.eq = eq; s.lt = lt; s.e = e;
        q.push_back(s);
    endtask

    // hc halt cycles, wf fetch waits, wm data-memory waits.
    task automatic add_instr(int idx, int hc, int wf, int wm, logic eq, logic lt);
        exp_t e;
        cur = tbl[idx];
        for (int i = 0; i < hc; i++) push(rb(), 1'b1, rb(), rb(), z(4'd0));
        for (int i = 0; i < wf; i++) begin
            e = z(4'd0); e.mreq = 1'b1;
            push(1'b0, 1'b0, rb(), rb(), e);
        end
        e = z(4'd0); e.mreq = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        push(1'b1, 1'b0, rb(), rb(), e);
        push(rb(), rb(), rb(), rb(), z(4'd1));
        case (cur.cls)
            C_ALU, C_LD, C_ST: begin
                e = z(4'd2); e.asl = cur.a; e.bsl = cur.b; e.aop = cur.aop;
                push(rb(), rb(), rb(), rb(), e);
                if (cur.cls == C_ALU) begin
                    e = z(4'd5); e.rwe = 1'b1; e.done = 1'b1;
                    push(rb(), rb(), rb(), rb(), e);
                end else if (cur.cls == C_LD) begin
                    e = z(4'd3); e.mreq = 1'b1; e.asel = 1'b1;
                    for (int i = 0; i < wm; i++) push(1'b0, rb(), rb(), rb(), e);
                    push(1'b1, rb(), rb(), rb(), e);
                    e = z(4'd5); e.rwe = 1'b1; e.done = 1'b1; e.wbs = 2'b01;
                    push(rb(), rb(), rb(), rb(), e);
                end else begin
                    e = z(4'd4); e.mreq = 1'b1; e.mwr = 1'b1; e.asel = 1'b1;
                    for (int i = 0; i < wm; i++) push(1'b0, rb(), rb(), rb(), e);
                    e.done = 1'b1;
                    push(1'b1, rb(), rb(), rb(), e);
                end
            end
            C_BR: begin
                e = z(4'd6); e.asl = 2'b01; e.bsl = 1'b1; e.pcs = 2'b01; e.done = 1'b1;
                e.bu  = (cur.f3 == 3'b110) || (cur.f3 == 3'b111);
                e.pcw = taken(cur.f3, eq, lt);
                push(rb(), rb(), eq, lt, e);
            end
            C_JAL, C_JALR: begin
                e = z(4'd7); e.bsl = 1'b1; e.rwe = 1'b1; e.wbs = 2'b10; e.pcw = 1'b1; e.done = 1'b1;
                e.asl = (cur.cls == C_JAL) ? 2'b01 : 2'b00;
                e.pcs = (cur.cls == C_JAL) ? 2'b01 : 2'b10;
                push(rb(), rb(), rb(), rb(), e);
            end
            default: begin
                e = z(4'd8); e.ill = 1'b1;
                for (int i = 0; i < 20; i++) push(rb(), rb(), rb(), rb(), e);
            end
        endcase
    endtask

    task automatic chk(exp_t e, string tag);
        exp_t o;
        o = observed();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Replays queued steps: inputs applied on the falling edge, outputs checked 1ns later.
    task automatic run(int n);
        int k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            bus.opcode = s.op; bus.funct3 = s.f3; bus.funct7 = s.f7;
            bus.mem_ready = s.rdy; bus.halt = s.hlt; bus.equal = s.eq; bus.lessThan = s.lt;
            #1;
            chk(s.e, $sformatf("step state=%0d", s.e.st));
            k++;
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk(z(4'd0), "reset_assert");
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1 chk(z(4'd0), "reset_held");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.halt = 1'b0;
        rst_n = 1'b1;
        #1;
        e = z(4'd0); e.mreq = 1'b1;
        chk(e, "first_fetch_after_reset");
    endtask

    initial begin
        exp_t e;
        int   idx;
        init_tbl();
        bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
        bus.equal = 1'b0; bus.lessThan = 1'b0; bus.halt = 1'b0; bus.mem_ready = 1'b0;
        #1 chk(z(4'd0), "power_on_reset");
        do_reset();

        add_instr(0, 0, 0, 0, 1'b0, 1'b0);  run(-1);   // add
        add_instr(20, 0, 0, 2, 1'b0, 1'b0); run(-1);   // lw, 2 data waits
        add_instr(29, 0, 0, 0, 1'b0, 1'b1); run(-1);   // bltu taken
        add_instr(30, 0, 0, 0, 1'b0, 1'b1); run(-1);   // bgeu not taken
        add_instr(32, 1, 1, 0, 1'b0, 1'b0); run(-1);   // jalr
        add_instr(33, 0, 0, 0, 1'b0, 1'b0); run(-1);   // opcode 1111111
        do_reset();
        add_instr(35, 0, 0, 0, 1'b0, 1'b0); run(-1);   // funct7=0000001
        do_reset();

        // Reset during a stalled store, then halt held across release.
        add_instr(22, 0, 0, 3, 1'b0, 1'b0);
        run(4);
        q.delete();
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        e = z(4'd4); e.mreq = 1'b1; e.mwr = 1'b1; e.asel = 1'b1;
        chk(e, "mem_wr_waiting");
        #2 rst_n = 1'b0;
        #1 chk(z(4'd0), "reset_drops_mem_req");
        @(negedge clk);
        bus.halt = 1'b1;
        rst_n = 1'b1;
        #1 chk(z(4'd0), "halt_after_release_0");
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = rb();
            #1 chk(z(4'd0), $sformatf("halt_after_release_%0d", i));
        end
        @(negedge clk);
        bus.halt = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        e = z(4'd0); e.mreq = 1'b1;
        chk(e, "fetch_after_halt_drop");

        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, NINS - 1);
            add_instr(idx, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                      rb(), rb());
            run(-1);
            if (tbl[idx].cls == C_TRAP) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
